// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : Sequential instruction fetch with an in-order response queue,
//            credit-based request issue and redirect flush of stale fetches.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [63:0]            imem_req_addr,
    input  logic                   imem_resp_valid,
    input  logic [31:0]            imem_resp_data,
    input  logic                   redirect_valid,
    input  logic [63:0]            redirect_pc,
    output logic                   inst_valid,
    input  logic                   inst_ready,
    output logic [31:0]            inst_data,
    output logic [63:0]            inst_pc,
    output logic [63:0]            inst_pc_plus4,
    output logic [$clog2(DEPTH):0] count
);

    localparam int                 c_PTR_W     = $clog2(DEPTH);
    localparam int                 c_CNT_W     = c_PTR_W + 1;
    localparam logic [c_CNT_W:0]   c_DEPTH_EXT = DEPTH[c_CNT_W:0];

    logic [63:0]        r_fetch_pc;
    logic [c_CNT_W-1:0] r_inflight;
    logic [c_CNT_W-1:0] r_drop;
    logic [c_CNT_W-1:0] r_count;
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [31:0]        r_q_data [DEPTH];
    logic [63:0]        r_q_pc   [DEPTH];
    logic [63:0]        r_pf_pc  [DEPTH];
    logic [c_PTR_W-1:0] r_pf_wr;
    logic [c_PTR_W-1:0] r_pf_rd;

    logic [c_CNT_W:0]   w_used;
    logic               w_credit;
    logic               w_req_fire;
    logic               w_drop_nz;
    logic               w_push;
    logic               w_pop;
    logic [63:0]        w_resp_pc;
    logic               w_unused;

    assign w_used     = {1'b0, r_count} + {1'b0, r_inflight};
    assign w_credit   = w_used < c_DEPTH_EXT;
    assign w_drop_nz  = r_drop != '0;
    assign w_req_fire = imem_req_valid && imem_req_ready;
    assign w_push     = imem_resp_valid && !redirect_valid && !w_drop_nz;
    assign w_pop      = inst_valid && inst_ready;
    assign w_resp_pc  = r_pf_pc[r_pf_rd];
    assign w_unused   = &{1'b0, redirect_pc[1:0]};

    // Reset gates the request so it drops immediately on async assertion.
    assign imem_req_valid = reset && w_credit && !redirect_valid;
    assign imem_req_addr  = r_fetch_pc;

    assign inst_valid    = r_count != '0;
    assign inst_data     = r_q_data[r_head];
    assign inst_pc       = r_q_pc[r_head];
    assign inst_pc_plus4 = inst_pc + 64'd4;
    assign count         = r_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_fetch_pc <= RESET_PC;
            r_inflight <= '0;
            r_drop     <= '0;
        end else begin
            r_inflight <= r_inflight + c_CNT_W'(w_req_fire) - c_CNT_W'(imem_resp_valid);
            if (redirect_valid) begin
                r_fetch_pc <= {redirect_pc[63:2], 2'b00};
                // Everything still outstanding after this cycle is stale.
                r_drop     <= r_inflight - c_CNT_W'(imem_resp_valid);
            end else begin
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + 64'd4;
                end
                if (imem_resp_valid && w_drop_nz) begin
                    r_drop <= r_drop - c_CNT_W'(1);
                end
            end
        end
    end

    // Per-request PC tags; stale responses still consume their tag, so the
    // FIFO is never flushed by a redirect.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pf_wr <= '0;
            r_pf_rd <= '0;
        end else begin
            if (w_req_fire) begin
                r_pf_wr <= r_pf_wr + c_PTR_W'(1);
            end
            if (imem_resp_valid) begin
                r_pf_rd <= r_pf_rd + c_PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_req_fire) begin
            r_pf_pc[r_pf_wr] <= r_fetch_pc;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_q_data[i] <= '0;
                r_q_pc[i]   <= '0;
            end
        end else if (redirect_valid) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_q_data[r_tail] <= imem_resp_data;
                r_q_pc[r_tail]   <= w_resp_pc;
                r_tail           <= r_tail + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + c_PTR_W'(1);
            end
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        end
    end

endmodule
`default_nettype wire
